// File: rtl/vga_pkg.sv
// vga_pkg: shared VGA console constants, default timing geometry and the ball sequencer state type
package vga_pkg;

    localparam logic [15:0] RED     = 16'hF800;
    localparam logic [15:0] GREEN   = 16'h07E0;
    localparam logic [15:0] BLUE    = 16'h001F;
    localparam logic [15:0] YELLOW  = 16'hFFE0;
    localparam logic [15:0] MAGENTA = 16'hF81F;
    localparam logic [15:0] CYAN    = 16'h07FF;
    localparam logic [15:0] BLACK   = 16'h0000;
    localparam logic [15:0] WHITE   = 16'hFFFF;

    localparam int H_ACTIVE_DEF = 640;
    localparam int V_ACTIVE_DEF = 480;

    typedef enum logic [1:0] {IDLE, MOVE, CHECK, COMMIT} ball_state_t;

endpackage

// File: rtl/ball_motion_ctrl_if.sv
// ball_motion_ctrl_if: raster inputs from vgaDriver and ball state outputs of the motion controller
interface ball_motion_ctrl_if;

    logic        vsync_i;
    logic        enable_i;
    logic [15:0] hpos_i;
    logic [15:0] vpos_i;
    logic [15:0] ball_hpos_o;
    logic [15:0] ball_vpos_o;
    logic        bounce_o;
    logic [15:0] frame_cnt_o;
    logic        ball_gfx_o;

    modport master (
        output vsync_i, enable_i, hpos_i, vpos_i,
        input  ball_hpos_o, ball_vpos_o, bounce_o, frame_cnt_o, ball_gfx_o
    );

    modport slave (
        input  vsync_i, enable_i, hpos_i, vpos_i,
        output ball_hpos_o, ball_vpos_o, bounce_o, frame_cnt_o, ball_gfx_o
    );

endinterface

// File: rtl/frame_tick_gen.sv
// frame_tick_gen: single-cycle pulse on each rising edge of the sampled vsync
module frame_tick_gen (
    input  logic VGA_IN_CLK,
    input  logic reset,
    input  logic vsync_i,
    output logic tick_o
);

    logic vsync_q;

    // previous-cycle copy of vsync for edge detection
    always_ff @(posedge VGA_IN_CLK) begin
        vsync_q <= reset ? 1'b0 : vsync_i;
    end

    assign tick_o = vsync_i & ~vsync_q;

endmodule

// File: rtl/ball_motion_ctrl.sv
// ball_motion_ctrl: per-frame advance/clamp/reflect/commit of the ball position; BALL_GFX_EN adds the pixel hit flag
module ball_motion_ctrl
    import vga_pkg::*;
#(
    parameter int H_ACTIVE = H_ACTIVE_DEF,
    parameter int V_ACTIVE = V_ACTIVE_DEF,
    parameter int SIZE     = 4,
    parameter int H_INIT   = 128,
    parameter int V_INIT   = 128,
    parameter int SPEED    = 2
) (
    input  logic              VGA_IN_CLK,
    input  logic              reset,
    ball_motion_ctrl_if.slave bus
);

    localparam logic signed [16:0] H_MAX = 17'(H_ACTIVE - SIZE);
    localparam logic signed [16:0] V_MAX = 17'(V_ACTIVE - SIZE);
    localparam logic [15:0]        SPD   = 16'(SPEED);

    ball_state_t        state_q, state_d;
    logic               tick;
    logic signed [16:0] nx_q, nx_d, ny_q, ny_d;
    logic [15:0]        vx_q, vx_d, vy_q, vy_d;
    logic [15:0]        ball_x_q, ball_x_d, ball_y_q, ball_y_d;
    logic [15:0]        fcnt_q, fcnt_d;
    logic               hit_q, hit_d, bounce_q, bounce_d;

    frame_tick_gen u_tick (
        .VGA_IN_CLK (VGA_IN_CLK),
        .reset      (reset),
        .vsync_i    (bus.vsync_i),
        .tick_o     (tick)
    );

    // sequencer state and datapath registers; reset aborts any frame in flight
    always_ff @(posedge VGA_IN_CLK) begin
        if (reset) begin
            state_q  <= IDLE;
            nx_q     <= '0;
            ny_q     <= '0;
            vx_q     <= -SPD;
            vy_q     <= SPD;
            ball_x_q <= 16'(H_INIT);
            ball_y_q <= 16'(V_INIT);
            fcnt_q   <= '0;
            hit_q    <= 1'b0;
            bounce_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            nx_q     <= nx_d;
            ny_q     <= ny_d;
            vx_q     <= vx_d;
            vy_q     <= vy_d;
            ball_x_q <= ball_x_d;
            ball_y_q <= ball_y_d;
            fcnt_q   <= fcnt_d;
            hit_q    <= hit_d;
            bounce_q <= bounce_d;
        end
    end

    // advance, clamp and reflect each axis independently, then publish once per frame
    always_comb begin
        state_d  = state_q;
        nx_d     = nx_q;
        ny_d     = ny_q;
        vx_d     = vx_q;
        vy_d     = vy_q;
        ball_x_d = ball_x_q;
        ball_y_d = ball_y_q;
        fcnt_d   = fcnt_q;
        hit_d    = hit_q;
        bounce_d = 1'b0;
        case (state_q)
            IDLE: state_d = tick ? MOVE : IDLE;
            MOVE: begin
                nx_d    = {1'b0, ball_x_q} + (bus.enable_i ? {vx_q[15], vx_q} : 17'd0);
                ny_d    = {1'b0, ball_y_q} + (bus.enable_i ? {vy_q[15], vy_q} : 17'd0);
                state_d = CHECK;
            end
            CHECK: begin
                nx_d    = nx_q[16] ? 17'sd0 : (nx_q > H_MAX ? H_MAX : nx_q);
                ny_d    = ny_q[16] ? 17'sd0 : (ny_q > V_MAX ? V_MAX : ny_q);
                vx_d    = nx_q[16] ? SPD : (nx_q > H_MAX ? -SPD : vx_q);
                vy_d    = ny_q[16] ? SPD : (ny_q > V_MAX ? -SPD : vy_q);
                hit_d   = nx_q[16] | (nx_q > H_MAX) | ny_q[16] | (ny_q > V_MAX);
                state_d = COMMIT;
            end
            COMMIT: begin
                ball_x_d = nx_q[15:0];
                ball_y_d = ny_q[15:0];
                bounce_d = hit_q;
                fcnt_d   = fcnt_q + 16'd1;
                state_d  = IDLE;
            end
        endcase
    end

    assign bus.ball_hpos_o = ball_x_q;
    assign bus.ball_vpos_o = ball_y_q;
    assign bus.bounce_o    = bounce_q;
    assign bus.frame_cnt_o = fcnt_q;

`ifdef BALL_GFX_EN
    logic gfx_q;

    // pixel-in-ball test; unsigned differences make pixels left of or above the ball wrap to large values
    always_ff @(posedge VGA_IN_CLK) begin
        gfx_q <= reset ? 1'b0 : ((bus.hpos_i - ball_x_q) < 16'(SIZE)) && ((bus.vpos_i - ball_y_q) < 16'(SIZE));
    end

    assign bus.ball_gfx_o = gfx_q;
`else
    logic unused_pix;

    assign unused_pix     = ^{bus.hpos_i, bus.vpos_i};
    assign bus.ball_gfx_o = 1'b0;
`endif

endmodule
